// File: rtl/risk_detection_unit.sv
// ID-stage hazard unit: load-use and branch/jump stalls, sticky HALT,
// debug step enable and saturating stall statistics.
module risk_detection_unit #(
  parameter int NB_REG              = 5,
  parameter int NB_OP               = 6,
  parameter int NB_FUNCT            = 6,
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_STALL_CYCLES = 1,
  parameter int NB_CNT              = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NB_REG-1:0]   i_if_id_rs,
  input  logic [NB_REG-1:0]   i_if_id_rt,
  input  logic [NB_OP-1:0]    i_if_id_op,
  input  logic [NB_FUNCT-1:0] i_if_id_funct,
  input  logic [NB_REG-1:0]   i_id_ex_rt,
  input  logic [NB_OP-1:0]    i_id_ex_op,
  output logic                o_stall,
  output logic                o_ctr_reg_src,
  output logic                o_jmp_stop,
  output logic                o_halt,
  output logic [NB_CNT-1:0]   o_load_stall_cnt,
  output logic [NB_CNT-1:0]   o_jmp_stall_cnt
);

  localparam int MAX_STALL = (LOAD_STALL_CYCLES > BRANCH_STALL_CYCLES) ?
                             LOAD_STALL_CYCLES : BRANCH_STALL_CYCLES;
  localparam int NB_SCNT = $clog2(MAX_STALL) + 1;

  localparam logic [NB_SCNT-1:0] SCNT_ONE = NB_SCNT'(1);
  localparam logic [NB_SCNT-1:0] LD_INIT  = NB_SCNT'(LOAD_STALL_CYCLES - 1);
  localparam logic [NB_SCNT-1:0] JMP_INIT = NB_SCNT'(BRANCH_STALL_CYCLES - 1);

  localparam logic [NB_OP-1:0] OP_RTYPE = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OP_BEQ   = NB_OP'(6'b000100);
  localparam logic [NB_OP-1:0] OP_BNE   = NB_OP'(6'b000101);
  localparam logic [NB_OP-1:0] OP_LB    = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_LH    = NB_OP'(6'b100001);
  localparam logic [NB_OP-1:0] OP_LW    = NB_OP'(6'b100011);
  localparam logic [NB_OP-1:0] OP_LBU   = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_LHU   = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_LWU   = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SB    = NB_OP'(6'b101000);
  localparam logic [NB_OP-1:0] OP_SH    = NB_OP'(6'b101001);
  localparam logic [NB_OP-1:0] OP_SW    = NB_OP'(6'b101011);
  localparam logic [NB_OP-1:0] OP_HALT  = NB_OP'(6'b111111);

  localparam logic [NB_FUNCT-1:0] FN_JR   = NB_FUNCT'(6'b001000);
  localparam logic [NB_FUNCT-1:0] FN_JALR = NB_FUNCT'(6'b001001);

  typedef enum logic [2:0] {
    RUN,
    LD_STALL,
    JMP_STALL,
    RELEASE,
    HALTED
  } state_t;

  state_t              state_q, state_d;
  logic [NB_SCNT-1:0]  cnt_q, cnt_d;
  logic [NB_CNT-1:0]   ld_cnt_q, jmp_cnt_q;

  logic ex_is_load;
  logic id_is_rtype;
  logic id_is_jmp;
  logic id_reads_rt;
  logic id_is_halt;
  logic load_haz;
  logic jmp_haz;

  logic stall;
  logic jmp_stop;
  logic halt;
  logic ld_inc;
  logic jmp_inc;

  always_comb begin
    ex_is_load = 1'b0;
    case (i_id_ex_op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: ex_is_load = 1'b1;
      default: ex_is_load = 1'b0;
    endcase
  end

  assign id_is_rtype = (i_if_id_op == OP_RTYPE);
  assign id_is_halt  = (i_if_id_op == OP_HALT);

  assign id_is_jmp = (i_if_id_op == OP_BEQ) ||
                     (i_if_id_op == OP_BNE) ||
                     (id_is_rtype &&
                      ((i_if_id_funct == FN_JR) ||
                       (i_if_id_funct == FN_JALR)));

  assign id_reads_rt = id_is_rtype ||
                       (i_if_id_op == OP_BEQ) ||
                       (i_if_id_op == OP_BNE) ||
                       (i_if_id_op == OP_SB) ||
                       (i_if_id_op == OP_SH) ||
                       (i_if_id_op == OP_SW);

  assign load_haz = ex_is_load &&
                    (i_id_ex_rt != '0) &&
                    ((i_id_ex_rt == i_if_id_rs) ||
                     (id_reads_rt && (i_id_ex_rt == i_if_id_rt)));

  assign jmp_haz = id_is_jmp;

  // HALT is checked ahead of the state decode so no stall or release masks it
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    jmp_stop = 1'b0;
    halt     = 1'b0;
    ld_inc   = 1'b0;
    jmp_inc  = 1'b0;
    if (state_q == HALTED) begin
      halt = 1'b1;
    end else if (id_is_halt) begin
      halt    = 1'b1;
      state_d = HALTED;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_haz) begin
            stall  = 1'b1;
            ld_inc = 1'b1;
            if (LOAD_STALL_CYCLES <= 1) begin
              state_d = RELEASE;
            end else begin
              state_d = LD_STALL;
              cnt_d   = LD_INIT;
            end
          end else if (jmp_haz) begin
            stall    = 1'b1;
            jmp_stop = 1'b1;
            jmp_inc  = 1'b1;
            if (BRANCH_STALL_CYCLES <= 1) begin
              state_d = RELEASE;
            end else begin
              state_d = JMP_STALL;
              cnt_d   = JMP_INIT;
            end
          end
        end
        LD_STALL: begin
          stall  = 1'b1;
          ld_inc = 1'b1;
          if (cnt_q <= SCNT_ONE) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - SCNT_ONE;
          end
        end
        JMP_STALL: begin
          stall    = 1'b1;
          jmp_stop = 1'b1;
          jmp_inc  = 1'b1;
          if (cnt_q <= SCNT_ONE) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - SCNT_ONE;
          end
        end
        RELEASE: begin
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ld_cnt_q  <= '0;
      jmp_cnt_q <= '0;
    end else if (i_enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ld_inc && (ld_cnt_q != '1)) begin
        ld_cnt_q <= ld_cnt_q + 1'b1;
      end
      if (jmp_inc && (jmp_cnt_q != '1)) begin
        jmp_cnt_q <= jmp_cnt_q + 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is held, even if ID shows a hazard
  assign o_stall          = stall & ~i_reset;
  assign o_ctr_reg_src    = stall & ~i_reset;
  assign o_jmp_stop       = jmp_stop & ~i_reset;
  assign o_halt           = halt & ~i_reset;
  assign o_load_stall_cnt = ld_cnt_q;
  assign o_jmp_stall_cnt  = jmp_cnt_q;

endmodule

// File: tb/tb_risk_detection_unit.sv
// Directed bench: dut_a (3-cycle load / 2-cycle branch stalls) and
// dut_b (1-cycle stalls, 2-bit statistics) share one stimulus stream.
module tb_risk_detection_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_JR   = 6'b001000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic [5:0] if_id_op, if_id_funct, id_ex_op;

  logic        a_stall, a_ctr, a_jmp, a_halt;
  logic [15:0] a_ld, a_jc;
  logic        b_stall, b_ctr, b_jmp, b_halt;
  logic [1:0]  b_ld, b_jc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risk_detection_unit #(
    .LOAD_STALL_CYCLES(3),
    .BRANCH_STALL_CYCLES(2),
    .NB_CNT(16)
  ) dut_a (
    .i_clk(clk), .i_reset(rst), .i_enable(enable),
    .i_if_id_rs(if_id_rs), .i_if_id_rt(if_id_rt),
    .i_if_id_op(if_id_op), .i_if_id_funct(if_id_funct),
    .i_id_ex_rt(id_ex_rt), .i_id_ex_op(id_ex_op),
    .o_stall(a_stall), .o_ctr_reg_src(a_ctr),
    .o_jmp_stop(a_jmp), .o_halt(a_halt),
    .o_load_stall_cnt(a_ld), .o_jmp_stall_cnt(a_jc)
  );

  risk_detection_unit #(
    .LOAD_STALL_CYCLES(1),
    .BRANCH_STALL_CYCLES(1),
    .NB_CNT(2)
  ) dut_b (
    .i_clk(clk), .i_reset(rst), .i_enable(enable),
    .i_if_id_rs(if_id_rs), .i_if_id_rt(if_id_rt),
    .i_if_id_op(if_id_op), .i_if_id_funct(if_id_funct),
    .i_id_ex_rt(id_ex_rt), .i_id_ex_op(id_ex_op),
    .o_stall(b_stall), .o_ctr_reg_src(b_ctr),
    .o_jmp_stop(b_jmp), .o_halt(b_halt),
    .o_load_stall_cnt(b_ld), .o_jmp_stall_cnt(b_jc)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [5:0] xop, input logic [4:0] xrt);
    if_id_op    = op;
    if_id_funct = fn;
    if_id_rs    = rs;
    if_id_rt    = rt;
    id_ex_op    = xop;
    id_ex_rt    = xrt;
  endtask

  task automatic set_idle();
    set_in(OP_R, FN_ADD, 5'd0, 5'd0, OP_R, 5'd0);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    set_idle();
    #2;
    chk("rst_a_stall", 16'(a_stall), 16'd0);
    chk("rst_a_ctr", 16'(a_ctr), 16'd0);
    chk("rst_a_jmp", 16'(a_jmp), 16'd0);
    chk("rst_a_halt", 16'(a_halt), 16'd0);
    chk("rst_a_ld", a_ld, 16'd0);
    chk("rst_a_jc", a_jc, 16'd0);
    chk("rst_b_ld", 16'(b_ld), 16'd0);
    tick();
    rst = 1'b0;

    // LW r3 in EX, ADD using r3 in ID
    set_in(OP_R, FN_ADD, 5'd3, 5'd7, OP_LW, 5'd3);
    #2;
    chk("lu_a_c1_stall", 16'(a_stall), 16'd1);
    chk("lu_a_c1_ctr", 16'(a_ctr), 16'd1);
    chk("lu_b_c1_stall", 16'(b_stall), 16'd1);
    chk("lu_b_c1_jmp", 16'(b_jmp), 16'd0);
    tick();
    set_in(OP_R, FN_ADD, 5'd3, 5'd7, OP_R, 5'd0);
    #2;
    chk("lu_b_c2_stall", 16'(b_stall), 16'd0);
    chk("lu_b_ld", 16'(b_ld), 16'd1);
    chk("lu_a_c2_stall", 16'(a_stall), 16'd1);
    tick();
    #2;
    chk("lu_a_c3_stall", 16'(a_stall), 16'd1);
    tick();
    #2;
    chk("lu_a_c4_stall", 16'(a_stall), 16'd0);
    chk("lu_a_ld", a_ld, 16'd3);
    tick();

    // SW reading r5 as rt, three stall cycles then a masked release
    set_in(OP_SW, 6'd0, 5'd1, 5'd5, OP_LW, 5'd5);
    #2;
    chk("sw_c1_stall", 16'(a_stall), 16'd1);
    chk("sw_c1_jmp", 16'(a_jmp), 16'd0);
    tick();
    #2;
    chk("sw_c2_stall", 16'(a_stall), 16'd1);
    tick();
    #2;
    chk("sw_c3_stall", 16'(a_stall), 16'd1);
    tick();
    #2;
    chk("sw_rel_stall", 16'(a_stall), 16'd0);
    chk("sw_rel_ctr", 16'(a_ctr), 16'd0);
    chk("sw_ld", a_ld, 16'd6);
    tick();
    set_in(OP_SW, 6'd0, 5'd0, 5'd0, OP_LW, 5'd0);
    #2;
    chk("sw_r0_stall", 16'(a_stall), 16'd0);
    tick();

    // BEQ held in ID: two jump stalls, then release without re-trigger
    set_in(OP_BEQ, 6'd0, 5'd1, 5'd2, OP_R, 5'd0);
    #2;
    chk("beq_c1_stall", 16'(a_stall), 16'd1);
    chk("beq_c1_jmp", 16'(a_jmp), 16'd1);
    tick();
    #2;
    chk("beq_c2_stall", 16'(a_stall), 16'd1);
    chk("beq_c2_jmp", 16'(a_jmp), 16'd1);
    tick();
    #2;
    chk("beq_rel_stall", 16'(a_stall), 16'd0);
    chk("beq_rel_jmp", 16'(a_jmp), 16'd0);
    chk("beq_jc", a_jc, 16'd2);
    tick();
    set_in(OP_ADDI, FN_JR, 5'd1, 5'd2, OP_R, 5'd0);
    #2;
    chk("addi_stall", 16'(a_stall), 16'd0);
    chk("addi_jmp", 16'(a_jmp), 16'd0);
    tick();

    // JR on a loaded register: load stall wins
    set_in(OP_R, FN_JR, 5'd4, 5'd0, OP_LW, 5'd4);
    #2;
    chk("jr_c1_stall", 16'(a_stall), 16'd1);
    chk("jr_c1_jmp", 16'(a_jmp), 16'd0);
    tick();
    #2;
    chk("jr_c2_jmp", 16'(a_jmp), 16'd0);
    tick();
    #2;
    chk("jr_c3_stall", 16'(a_stall), 16'd1);
    tick();
    #2;
    chk("jr_rel_stall", 16'(a_stall), 16'd0);
    chk("jr_jc", a_jc, 16'd2);
    chk("jr_ld", a_ld, 16'd9);
    set_idle();
    tick();

    // Debug step disabled for 4 cycles inside a load stall
    set_in(OP_R, FN_ADD, 5'd5, 5'd0, OP_LW, 5'd5);
    #2;
    chk("en_c1_stall", 16'(a_stall), 16'd1);
    tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("en_off_stall", 16'(a_stall), 16'd1);
      tick();
    end
    chk("en_off_ld", a_ld, 16'd10);
    enable = 1'b1;
    #2;
    chk("en_c2_stall", 16'(a_stall), 16'd1);
    tick();
    #2;
    chk("en_c3_stall", 16'(a_stall), 16'd1);
    tick();
    #2;
    chk("en_rel_stall", 16'(a_stall), 16'd0);
    chk("en_ld", a_ld, 16'd12);
    set_idle();
    tick();

    // HALT in ID together with a load hazard
    set_in(OP_HALT, 6'd0, 5'd4, 5'd0, OP_LW, 5'd4);
    #2;
    chk("halt_c1_halt", 16'(a_halt), 16'd1);
    chk("halt_c1_stall", 16'(a_stall), 16'd0);
    chk("halt_c1_ctr", 16'(a_ctr), 16'd0);
    chk("halt_b_halt", 16'(b_halt), 16'd1);
    tick();
    set_in(OP_R, FN_ADD, 5'd4, 5'd0, OP_LW, 5'd4);
    #2;
    chk("halted_halt", 16'(a_halt), 16'd1);
    chk("halted_stall", 16'(a_stall), 16'd0);
    tick();
    tick();
    #2;
    chk("halted_halt2", 16'(a_halt), 16'd1);
    chk("halted_ld", a_ld, 16'd12);
    chk("halted_jc", a_jc, 16'd2);

    set_idle();
    rst = 1'b1;
    #1;
    chk("rst2_halt", 16'(a_halt), 16'd0);
    chk("rst2_ld", a_ld, 16'd0);
    tick();
    rst = 1'b0;

    // Reset in the middle of a jump stall
    set_in(OP_BEQ, 6'd0, 5'd1, 5'd2, OP_R, 5'd0);
    #2;
    chk("mid_c1_stall", 16'(a_stall), 16'd1);
    tick();
    #2;
    chk("mid_c2_jmp", 16'(a_jmp), 16'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 16'(a_stall), 16'd0);
    chk("mid_rst_ctr", 16'(a_ctr), 16'd0);
    chk("mid_rst_jmp", 16'(a_jmp), 16'd0);
    chk("mid_rst_halt", 16'(a_halt), 16'd0);
    chk("mid_rst_jc", a_jc, 16'd0);
    tick();
    rst = 1'b0;
    #2;
    chk("post_rst_stall", 16'(a_stall), 16'd1);
    chk("post_rst_jmp", 16'(a_jmp), 16'd1);
    chk("post_rst_b_jmp", 16'(b_jmp), 16'd1);
    tick();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Five load stalls on the 2-bit counter of dut_b
    for (int i = 0; i < 5; i++) begin
      set_in(OP_R, FN_ADD, 5'd3, 5'd0, OP_LW, 5'd3);
      #2;
      chk("sat_b_stall", 16'(b_stall), 16'd1);
      tick();
      set_idle();
      #2;
      if (i == 2) chk("sat_b_ld3", 16'(b_ld), 16'd3);
      tick();
    end
    chk("sat_b_ld5", 16'(b_ld), 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/risk_detection_unit.md
Name: risk_detection_unit

Overview:
- Parametrised, stateful successor to the ID-stage hazard detector.
- Detects load-use and branch/jump-resolution hazards between IF/ID and ID/EX.
- Stalls the front end for a configurable number of cycles, each hazard instance counted exactly once, with no external stop feedback.
- Latches HALT, honours the debug-unit step enable, and keeps saturating stall statistics.

Parameters:
- NB_REG, 5, register index width
- NB_OP, 6, opcode width
- NB_FUNCT, 6, funct width
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard (>=1)
- BRANCH_STALL_CYCLES, 1, stall cycles per BEQ/BNE/JR/JALR (>=1)
- NB_CNT, 16, statistics counter width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  pipeline advance enable from debug unit
- i_if_id_rs  in  NB_REG  rs of instruction in ID
- i_if_id_rt  in  NB_REG  rt of instruction in ID
- i_if_id_op  in  NB_OP  opcode in ID
- i_if_id_funct  in  NB_FUNCT  funct in ID
- i_id_ex_rt  in  NB_REG  destination rt of instruction in EX
- i_id_ex_op  in  NB_OP  opcode in EX
- o_stall  out  1  hold PC and IF/ID
- o_ctr_reg_src  out  1  select zero control into ID/EX (bubble); equals o_stall
- o_jmp_stop  out  1  stall is due to branch/jump
- o_halt  out  1  sticky halt
- o_load_stall_cnt  out  NB_CNT  load-use stall cycles, saturating
- o_jmp_stall_cnt  out  NB_CNT  branch/jump stall cycles, saturating

Behaviour:
- Decode:
  - Loads: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, LWU 100111. LUI is not a load.
  - Branch/jump: BEQ 000100, BNE 000101, R-type 000000 with funct JR 001000 or JALR 001001. Funct is ignored for non-R-type opcodes.
  - HALT: 111111.
  - rt is read by R-type, BEQ, BNE, SB 101000, SH 101001, SW 101011. rs is always read.
- load_haz = EX op is a load AND i_id_ex_rt != 0 AND (i_id_ex_rt == rs OR (rt is read AND i_id_ex_rt == rt)).
- jmp_haz = ID holds a branch/jump.
- States: RUN, LD_STALL, JMP_STALL, RELEASE, HALTED. Counter width is clog2(max stall)+1.
- RUN:
  - load_haz takes priority over jmp_haz.
  - On a hazard, o_stall is asserted combinationally in the same cycle; this is stall cycle 1.
  - If N>1, go to LD_STALL/JMP_STALL with cnt=N-1. If N=1, go to RELEASE.
- LD_STALL/JMP_STALL:
  - o_stall=1 and detection is ignored.
  - cnt decrements each enabled cycle; leaving when cnt==1 goes to RELEASE.
- RELEASE:
  - o_stall=0 and load/jmp detection is masked for this cycle, so the held instruction advances without re-triggering.
  - Next state is RUN.
- o_jmp_stop=1 exactly in stall cycles caused by jmp_haz.
- HALT:
  - A HALT opcode in ID is never masked. o_halt=1 combinationally and the state goes to HALTED.
  - HALTED: o_halt=1, o_stall=0, counters frozen, exit only by reset.
  - HALT wins over both hazards in the same cycle.
- i_enable=0:
  - State, cnt and statistics are held.
  - Outputs are still driven from the current state and inputs.
  - No stall cycle is consumed or counted.
- Statistics:
  - Each enabled stall cycle increments the matching counter by 1.
  - Counters saturate at 2^NB_CNT-1 with no wrap.
- Reset (any time, including mid-stall): state=RUN, cnt=0, o_stall=0, o_ctr_reg_src=0, o_jmp_stop=0, o_halt=0, both counters=0. The first post-reset cycle evaluates hazards normally.

Test Plan:
- LOAD_STALL_CYCLES=1: EX=LW rt=3, ID=ADD rs=3 -> o_stall=1 for 1 cycle, then 0 with EX op=0; o_load_stall_cnt=1.
- LOAD_STALL_CYCLES=3: EX=LW rt=5, ID=SW rt=5 -> o_stall=1 for exactly 3 cycles, then 1 RELEASE cycle with o_stall=0; count=3. Repeat with rt=0 -> no stall.
- BRANCH_STALL_CYCLES=2: BEQ held in ID -> o_stall=o_jmp_stop=1 for 2 cycles, then 0 for 1 cycle with no re-trigger; o_jmp_stall_cnt=2. ADDI opcode with funct 001000 -> no stall.
- Simultaneous: EX=LW rt=4, ID=JR rs=4 -> load stall first (o_jmp_stop=0) -> then RELEASE/RUN. HALT in ID together with a load hazard -> o_halt=1, o_stall=0, held until reset.
- i_enable=0 for 4 cycles inside a 3-cycle load stall -> stall stretches by 4 cycles; count still 3.
- Reset asserted mid-JMP_STALL -> all outputs 0 immediately (async). NB_CNT=2 with 5 load stalls -> counter stops at 3.
